// File: rtl/pattern_signature_checker.sv
// ---------------------------------------------------------------------------
// pattern_signature_checker
//
// Exhaustive pattern generator plus 16-bit MISR signature checker for a
// single-output DUT. A run applies every IN_W-bit pattern in ascending order.
// Each pattern is held for SETTLE cycles and then sampled for one cycle, when
// the DUT response is folded into the MISR (polynomial 0x1021, seed 0xFFFF).
// After the last pattern the signature is compared once against golden_sig
// and the registered result is held in DONE until the next start or reset.
//
// Parameters
//   IN_W        width of the stimulus vector (1..16)
//   SETTLE      cycles each pattern is held before sampling (1..255)
//
// Ports
//   CK          clock; all state updates on the rising edge
//   reset       synchronous, active-low reset
//   start       level; begins a run when seen in IDLE or DONE
//   golden_sig  expected signature, sampled in COMPARE
//   dut_out     single-bit DUT response, folded in during SAMPLE
//   pattern_out registered stimulus vector driven to the DUT
//   busy        high in APPLY, SAMPLE and COMPARE
//   done        high only in DONE
//   sig         current MISR signature
//   mismatch    registered (sig != golden_sig); valid while done=1
// ---------------------------------------------------------------------------
module pattern_signature_checker #(
    parameter int IN_W   = 2,
    parameter int SETTLE = 1
) (
    input  logic            CK,
    input  logic            reset,
    input  logic            start,
    input  logic [15:0]     golden_sig,
    input  logic            dut_out,
    output logic [IN_W-1:0] pattern_out,
    output logic            busy,
    output logic            done,
    output logic [15:0]     sig,
    output logic            mismatch
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_APPLY   = 3'd1,
        S_SAMPLE  = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    localparam logic [15:0] MISR_SEED   = 16'hFFFF;
    localparam logic [15:0] MISR_POLY   = 16'h1021;
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);

    state_e          state_q,    state_d;
    logic [IN_W-1:0] pattern_q,  pattern_d;
    logic [15:0]     sig_q,      sig_d;
    logic            mismatch_q, mismatch_d;
    logic [7:0]      settle_q,   settle_d;

    // Next-state and datapath update.
    // NOTE: every signal written here gets a hold default first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        sig_d      = sig_q;
        mismatch_d = mismatch_q;
        settle_d   = settle_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_APPLY;
                    pattern_d  = '0;
                    sig_d      = MISR_SEED;
                    mismatch_d = 1'b0;
                    settle_d   = 8'd0;
                end
            end

            S_APPLY: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = S_SAMPLE;
                    settle_d = 8'd0;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end

            S_SAMPLE: begin
                // Shift left, fold back the polynomial when the MSB leaves,
                // then inject the DUT response into bit 0.
                sig_d = {sig_q[14:0], 1'b0}
                      ^ (sig_q[15] ? MISR_POLY : 16'h0000)
                      ^ {15'b0, dut_out};
                // Stop on the all-ones pattern so the counter never wraps.
                if (&pattern_q) begin
                    state_d = S_COMPARE;
                end else begin
                    pattern_d = pattern_q + IN_W'(1);
                    settle_d  = 8'd0;
                    state_d   = S_APPLY;
                end
            end

            S_COMPARE: begin
                mismatch_d = (sig_q != golden_sig);
                state_d    = S_DONE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values computed above.
    always_ff @(posedge CK) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pattern_q  <= '0;
            sig_q      <= MISR_SEED;
            mismatch_q <= 1'b0;
            settle_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            sig_q      <= sig_d;
            mismatch_q <= mismatch_d;
            settle_q   <= settle_d;
        end
    end

    assign pattern_out = pattern_q;
    assign sig         = sig_q;
    assign mismatch    = mismatch_q;
    assign busy        = (state_q == S_APPLY) || (state_q == S_SAMPLE)
                      || (state_q == S_COMPARE);
    assign done        = (state_q == S_DONE);

endmodule
